sram_stream_ctrl: RTL and testbench

SRAM_STREAM_CTRL -- requirements
Module: sram_stream_ctrl

---
 rtl/sram_stream_ctrl_if.sv | 52 +++++
 rtl/sram_stream_ctrl.sv | 147 ++++++++++++++
 tb/tb_sram_stream_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_stream_ctrl_if.sv
// Command, stream and SRAM-bus bundle for sram_stream_ctrl.
// The controller uses the master modport; the surrounding system/SRAM uses the slave modport.
interface sram_stream_ctrl_if #(
    parameter int num        = 2048,
    parameter int data_width = 32
);
    localparam int AW = $clog2(num);

    logic                  start;
    logic                  mode;
    logic [AW-1:0]         base;
    logic [AW:0]           len;

    logic [data_width-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    logic [data_width-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    logic                  CEN;
    logic                  WEN;
    logic [AW-1:0]         A;
    logic [data_width-1:0] D;
    logic [data_width-1:0] Q;

    logic                  busy;
    logic                  done;

    modport master (
        input  start, mode, base, len,
        input  in_data, in_valid,
        output in_ready,
        output out_data, out_valid,
        input  out_ready,
        output CEN, WEN, A, D,
        input  Q,
        output busy, done
    );

    modport slave (
        output start, mode, base, len,
        output in_data, in_valid,
        input  in_ready,
        input  out_data, out_valid,
        output out_ready,
        input  CEN, WEN, A, D,
        output Q,
        input  busy, done
    );
endinterface

// File: rtl/sram_stream_ctrl.sv
// Burst controller between a single-port SRAM and valid/ready write/read streams.
// Reads are credit-limited into a 3-entry FIFO so any out_ready pattern is lossless.
module sram_stream_ctrl #(
    parameter int num        = 2048,
    parameter int data_width = 32
) (
    input logic                CLK,
    input logic                RESET_N,
    sram_stream_ctrl_if.master bus
);
    localparam int AW         = $clog2(num);
    localparam int FIFO_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN
    } state_t;

    state_t                state, state_nxt;
    logic [AW-1:0]         addr, addr_nxt;
    logic [AW:0]           remaining, remaining_nxt;
    logic                  wr_acc;
    logic                  rd_vld_p0;
    logic                  rd_vld_p1;
    logic                  done_nxt;
    logic                  done_q;
    logic                  credit_ok;

    logic [1:0]            fifo_cnt;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [data_width-1:0] fifo_mem [FIFO_DEPTH];
    logic                  push;
    logic                  pop;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        if (a == AW'(num - 1)) return '0;
        return a + 1'b1;
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        if (p == 2'(FIFO_DEPTH - 1)) return 2'd0;
        return p + 2'd1;
    endfunction

    // A pop in the same cycle does not free a credit; this keeps the FIFO
    // from ever needing a fourth slot when out_ready drops.
    assign credit_ok = (3'(fifo_cnt) + 3'(rd_vld_p1)) < 3'(FIFO_DEPTH);

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        wr_acc        = 1'b0;
        rd_vld_p0     = 1'b0;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        addr_nxt      = bus.base;
                        remaining_nxt = bus.len;
                        state_nxt     = bus.mode ? READ : WRITE;
                    end
                end
            end
            WRITE: begin
                if (bus.in_valid) begin
                    wr_acc        = 1'b1;
                    addr_nxt      = addr_inc(addr);
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == (AW+1)'(1)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            READ: begin
                if (remaining != '0 && credit_ok) begin
                    rd_vld_p0     = 1'b1;
                    addr_nxt      = addr_inc(addr);
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == (AW+1)'(1)) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_cnt == 2'd0 && !rd_vld_p1) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: SRAM access is driven combinationally from the current state.
    assign bus.CEN       = ~(wr_acc | rd_vld_p0);
    assign bus.WEN       = ~wr_acc;
    assign bus.A         = (wr_acc | rd_vld_p0) ? addr : '0;
    assign bus.D         = wr_acc ? bus.in_data : '0;
    assign bus.in_ready  = (state == WRITE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.out_valid = (fifo_cnt != 2'd0);
    assign bus.out_data  = (fifo_cnt != 2'd0) ? fifo_mem[rd_ptr] : '0;

    assign push = rd_vld_p1;
    assign pop  = (fifo_cnt != 2'd0) && bus.out_ready;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // Stage p1: read data returns on Q one cycle after issue and is pushed.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            addr      <= '0;
            remaining <= '0;
            rd_vld_p1 <= 1'b0;
            done_q    <= 1'b0;
            fifo_cnt  <= 2'd0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
        end else begin
            addr      <= addr_nxt;
            remaining <= remaining_nxt;
            rd_vld_p1 <= rd_vld_p0;
            done_q    <= done_nxt;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= bus.Q;
    end
endmodule

// File: tb/tb_sram_stream_ctrl.sv
// Randomized self-checking bench for sram_stream_ctrl with an SRAM model
// and a reference memory image of what each write burst should have stored.
module tb_sram_stream_ctrl;
    localparam int NUM = 64;
    localparam int DW  = 32;
    localparam int AW  = $clog2(NUM);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_stream_ctrl_if #(.num(NUM), .data_width(DW)) bus ();

    sram_stream_ctrl #(.num(NUM), .data_width(DW)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    // Single-port synchronous SRAM: read data appears on Q the cycle after access.
    logic [DW-1:0] sram [NUM];
    logic [DW-1:0] sram_q;
    always @(posedge clk) begin
        if (!bus.CEN) begin
            if (!bus.WEN) sram[bus.A] <= bus.D;
            else          sram_q      <= sram[bus.A];
        end
    end
    assign bus.Q = sram_q;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [DW-1:0] ref_mem [NUM];

    int            wr_a[$];
    logic [DW-1:0] wr_d[$];
    int            wr_c[$];
    int            rd_a[$];
    int            rd_c[$];
    logic [DW-1:0] out_d[$];
    int            out_c[$];
    int            done_cnt, done_c, outstanding, max_out, stall_viol, busy_cnt;
    bit            prev_stall;
    logic [DW-1:0] prev_data;

    task automatic clear_mon();
        wr_a.delete(); wr_d.delete(); wr_c.delete();
        rd_a.delete(); rd_c.delete(); out_d.delete(); out_c.delete();
        done_cnt = 0; done_c = -1; outstanding = 0; max_out = 0;
        stall_viol = 0; busy_cnt = 0; prev_stall = 0; prev_data = '0;
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            if (!bus.CEN && !bus.WEN) begin
                wr_a.push_back(int'(bus.A)); wr_d.push_back(bus.D); wr_c.push_back(cyc);
            end
            if (!bus.CEN && bus.WEN) begin
                rd_a.push_back(int'(bus.A)); rd_c.push_back(cyc); outstanding++;
            end
            if (outstanding > max_out) max_out = outstanding;
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stall_viol++;
            if (bus.out_valid && bus.out_ready) begin
                out_d.push_back(bus.out_data); out_c.push_back(cyc); outstanding--;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
        if (bus.busy) busy_cnt++;
        if (bus.done) begin done_cnt++; done_c = cyc; end
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int b, input int l, input bit fixed, input bit rand_valid, input bit poke);
        logic [DW-1:0] exp_d[$];
        int i, budget, n, start_c;
        clear_mon();
        for (int k = 0; k < l; k++) exp_d.push_back(fixed ? DW'(32'hA0 + k) : DW'($urandom()));
        bus.mode = 1'b0; bus.base = AW'(b); bus.len = (AW+1)'(l); bus.start = 1'b1;
        tick();
        start_c = cyc; bus.start = 1'b0;
        i = 0; budget = 20 * l + 50;
        while (i < l && budget > 0) begin
            bus.in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data  = exp_d[i];
            if (poke && i == 1) begin
                bus.start = 1'b1; bus.mode = 1'b1; bus.base = '0; bus.len = (AW+1)'(5);
            end
            n = wr_a.size();
            tick();
            bus.start = 1'b0; bus.mode = 1'b0;
            if (wr_a.size() != n) i++;
            budget--;
        end
        bus.in_valid = 1'b0;
        repeat (5) tick();
        tests++;
        if (i !== l) begin fails++; $display("FAIL write_accept: got %0d words, expected %0d", i, l); end
        tests++;
        if (wr_a.size() !== l) begin fails++; $display("FAIL write_count: got %0d, expected %0d", wr_a.size(), l); end
        for (int k = 0; k < l && k < wr_a.size(); k++) begin
            tests++;
            if (wr_a[k] !== (b + k) % NUM) begin
                fails++; $display("FAIL write_addr[%0d]: got %0d, expected %0d", k, wr_a[k], (b + k) % NUM);
            end
            tests++;
            if (wr_d[k] !== exp_d[k]) begin
                fails++; $display("FAIL write_data[%0d]: got %h, expected %h", k, wr_d[k], exp_d[k]);
            end
        end
        tests++;
        if (done_cnt !== 1) begin fails++; $display("FAIL write_done_count: got %0d, expected 1", done_cnt); end
        if (wr_c.size() > 0) begin
            tests++;
            if (done_c !== wr_c[$] + 1) begin
                fails++; $display("FAIL write_done_cycle: got %0d, expected %0d", done_c, wr_c[$] + 1);
            end
        end
        tests++;
        if (rd_a.size() !== 0) begin fails++; $display("FAIL write_spurious_reads: got %0d, expected 0", rd_a.size()); end
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL write_busy_after: got %b, expected 0", bus.busy); end
        if (!rand_valid && wr_c.size() == l) begin
            tests++;
            if (wr_c[0] !== start_c + 1 || wr_c[l-1] - wr_c[0] !== l - 1) begin
                fails++; $display("FAIL write_timing: first %0d last %0d, expected %0d..%0d",
                                  wr_c[0], wr_c[l-1], start_c + 1, start_c + l);
            end
        end
        for (int k = 0; k < l; k++) ref_mem[(b + k) % NUM] = exp_d[k];
    endtask

    task automatic do_read(input int b, input int l, input int rmode);
        int budget, start_c;
        bit tog;
        clear_mon();
        bus.mode = 1'b1; bus.base = AW'(b); bus.len = (AW+1)'(l); bus.start = 1'b1;
        tick();
        start_c = cyc; bus.start = 1'b0; bus.mode = 1'b0;
        tog = 1'b0; budget = 40 * l + 50;
        while (out_d.size() < l && budget > 0) begin
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       begin tog = !tog; bus.out_ready = tog; end
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            budget--;
        end
        bus.out_ready = 1'b1;
        repeat (6) tick();
        bus.out_ready = 1'b0;
        tests++;
        if (out_d.size() !== l) begin fails++; $display("FAIL read_count: got %0d words, expected %0d", out_d.size(), l); end
        for (int k = 0; k < l && k < out_d.size(); k++) begin
            tests++;
            if (out_d[k] !== ref_mem[(b + k) % NUM]) begin
                fails++; $display("FAIL read_data[%0d]: got %h, expected %h", k, out_d[k], ref_mem[(b + k) % NUM]);
            end
        end
        tests++;
        if (rd_a.size() !== l) begin fails++; $display("FAIL read_issue_count: got %0d, expected %0d", rd_a.size(), l); end
        for (int k = 0; k < l && k < rd_a.size(); k++) begin
            tests++;
            if (rd_a[k] !== (b + k) % NUM) begin
                fails++; $display("FAIL read_addr[%0d]: got %0d, expected %0d", k, rd_a[k], (b + k) % NUM);
            end
        end
        tests++;
        if (max_out > 3) begin fails++; $display("FAIL read_outstanding: got %0d, expected at most 3", max_out); end
        tests++;
        if (stall_viol !== 0) begin fails++; $display("FAIL read_stall_stable: got %0d changes, expected 0", stall_viol); end
        tests++;
        if (done_cnt !== 1) begin fails++; $display("FAIL read_done_count: got %0d, expected 1", done_cnt); end
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL read_busy_after: got %b, expected 0", bus.busy); end
        tests++;
        if (wr_a.size() !== 0) begin fails++; $display("FAIL read_spurious_writes: got %0d, expected 0", wr_a.size()); end
        if (rmode == 0 && rd_c.size() == l && out_c.size() == l) begin
            tests++;
            if (rd_c[0] !== start_c + 1 || rd_c[l-1] - rd_c[0] !== l - 1) begin
                fails++; $display("FAIL read_issue_rate: first %0d last %0d, expected %0d..%0d",
                                  rd_c[0], rd_c[l-1], start_c + 1, start_c + l);
            end
            tests++;
            if (out_c[0] !== rd_c[0] + 2 || out_c[l-1] - out_c[0] !== l - 1) begin
                fails++; $display("FAIL read_latency: first out %0d last %0d, expected %0d..%0d",
                                  out_c[0], out_c[l-1], rd_c[0] + 2, rd_c[0] + l + 1);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (bus.CEN !== 1'b1)       begin fails++; $display("FAIL reset_CEN: got %b, expected 1", bus.CEN); end
        tests++; if (bus.WEN !== 1'b1)       begin fails++; $display("FAIL reset_WEN: got %b, expected 1", bus.WEN); end
        tests++; if (bus.in_ready !== 1'b0)  begin fails++; $display("FAIL reset_in_ready: got %b, expected 0", bus.in_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
        tests++; if (bus.busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0)      begin fails++; $display("FAIL reset_done: got %b, expected 0", bus.done); end
        tests++; if (bus.A !== '0)           begin fails++; $display("FAIL reset_A: got %h, expected 0", bus.A); end
        tests++; if (bus.D !== '0)           begin fails++; $display("FAIL reset_D: got %h, expected 0", bus.D); end
        tests++; if (bus.out_data !== '0)    begin fails++; $display("FAIL reset_out_data: got %h, expected 0", bus.out_data); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_write_basic();
        do_write(5, 4, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_read_basic();
        do_read(5, 4, 0);
    endtask

    task automatic test_wrap();
        do_write(NUM - 2, 4, 1'b0, 1'b0, 1'b0);
        do_read(NUM - 2, 4, 2);
    endtask

    task automatic test_backpressure();
        do_write(20, 8, 1'b0, 1'b1, 1'b0);
        do_read(20, 8, 1);
        do_write(30, 20, 1'b0, 1'b1, 1'b0);
        do_read(30, 20, 2);
    endtask

    task automatic test_zero_len();
        int s;
        for (int m = 0; m < 2; m++) begin
            clear_mon();
            bus.mode = 1'(m); bus.base = AW'(3); bus.len = '0; bus.start = 1'b1;
            tick();
            s = cyc; bus.start = 1'b0;
            repeat (4) tick();
            tests++;
            if (done_cnt !== 1 || done_c !== s + 1) begin
                fails++; $display("FAIL zero_len_done: count %0d at cycle %0d, expected 1 at %0d", done_cnt, done_c, s + 1);
            end
            tests++;
            if (wr_a.size() + rd_a.size() !== 0) begin
                fails++; $display("FAIL zero_len_access: got %0d accesses, expected 0", wr_a.size() + rd_a.size());
            end
            tests++;
            if (busy_cnt !== 0) begin fails++; $display("FAIL zero_len_busy: got %0d busy cycles, expected 0", busy_cnt); end
        end
    endtask

    task automatic test_start_ignored();
        do_write(40, 6, 1'b0, 1'b0, 1'b1);
        do_read(40, 6, 0);
    endtask

    task automatic test_reset_mid_burst();
        clear_mon();
        bus.out_ready = 1'b0;
        bus.mode = 1'b1; bus.base = AW'(5); bus.len = (AW+1)'(4); bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.mode = 1'b0;
        repeat (3) tick();
        tests++;
        if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL midrst_prefill: got out_valid %b, expected 1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid: got %b, expected 0", bus.out_valid); end
        tests++; if (bus.busy !== 1'b0)      begin fails++; $display("FAIL midrst_busy: got %b, expected 0", bus.busy); end
        tests++; if (bus.CEN !== 1'b1)       begin fails++; $display("FAIL midrst_CEN: got %b, expected 1", bus.CEN); end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        tests++;
        if (done_cnt !== 0) begin fails++; $display("FAIL midrst_done: got %0d pulses, expected 0", done_cnt); end
        tests++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_stale: got out_valid %b, expected 0", bus.out_valid); end
        do_read(5, 4, 0);
    endtask

    task automatic test_back_to_back();
        int b, l;
        for (int k = 0; k < 5; k++) begin
            b = $urandom_range(0, NUM - 1);
            l = $urandom_range(1, 12);
            do_write(b, l, 1'b0, 1'b1, 1'b0);
            do_read(b, l, 2);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 1'b0; bus.base = '0; bus.len = '0;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        clear_mon();
        test_reset();
        test_write_basic();
        test_read_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_start_ignored();
        test_reset_mid_burst();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
